// File: rtl/clk_divider_prog_mc_if.sv
// clk_divider_prog_mc_if: divider bus; master drives en/cfg_we/cfg_ch/cfg_half, slave returns divided_clk/tick/cfg_pending
interface clk_divider_prog_mc_if #(
  parameter int CNT_W  = 32,
  parameter int NUM_CH = 4
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0] en;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic [NUM_CH-1:0] divided_clk;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] cfg_pending;
  modport master (output en, cfg_we, cfg_ch, cfg_half, input divided_clk, tick, cfg_pending);
  modport slave  (input en, cfg_we, cfg_ch, cfg_half, output divided_clk, tick, cfg_pending);
endinterface

// File: rtl/clk_divider_prog_mc.sv
// clk_divider_prog_mc: per-channel programmable 50% clock divider + toggle tick; ports clk, rst_n (async low), bus (slave: en/cfg in, divided_clk/tick/cfg_pending out)
module clk_divider_prog_mc #(
  parameter int          CNT_W        = 32,
  parameter int          NUM_CH       = 4,
  parameter int unsigned DEFAULT_HALF = 250000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clk_divider_prog_mc_if.slave bus
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] H0 = CNT_W'(DEFAULT_HALF);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] r_cnt, r_act, r_shadow;
    logic             r_div, r_tick, r_pend;
    logic             w_term, w_apply, w_wr;
    assign w_term  = bus.en[c] && r_cnt == r_act;
    assign w_apply = r_pend && (!bus.en[c] || (w_term && r_div));
    assign w_wr    = bus.cfg_we && bus.cfg_ch == CH_W'(c);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt    <= '0;
        r_act    <= H0;
        r_shadow <= H0;
        r_div    <= 1'b0;
        r_tick   <= 1'b0;
        r_pend   <= 1'b0;
      end else begin
        if (!bus.en[c]) begin
          r_cnt  <= '0;
          r_div  <= 1'b0;
          r_tick <= 1'b0;
        end else if (w_term) begin
          r_cnt  <= '0;
          r_div  <= ~r_div;
          r_tick <= 1'b1;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
          r_tick <= 1'b0;
        end
        if (w_apply) begin
          r_act  <= r_shadow;
          r_pend <= 1'b0;
        end
        if (w_wr) begin
          r_shadow <= bus.cfg_half;
          r_pend   <= 1'b1;
        end
      end
    end
    assign bus.divided_clk[c] = r_div;
    assign bus.tick[c]        = r_tick;
    assign bus.cfg_pending[c] = r_pend;
  end
endmodule
